controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 155 +++++++++++++++
 tb/tb_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
//
// Main decoder for a single-cycle MIPS-style datapath. Every control output and
// the illegal flag are decoded combinationally from the opcode, function field
// and ALU zero flag, so they change in the same time step as their inputs and
// ignore both clk and rst_n. The only state is err_sticky. It latches any
// illegal decode seen at a rising clock edge and is cleared only by rst_n.
//
// Ports
//   clk         in   1  rising-edge clock (err_sticky register only)
//   rst_n       in   1  asynchronous active-low reset (err_sticky only)
//   op          in   6  instruction opcode, bits [31:26]
//   funct       in   6  R-type function field, bits [5:0]
//   zero        in   1  ALU zero flag, used for BEQ
//   memtoreg    out  1  write-back data comes from memory
//   memwrite    out  1  data memory write enable
//   memread     out  1  data memory read enable
//   pcsrc       out  1  take branch target
//   ULAsrc      out  1  ALU operand B comes from the sign-extended immediate
//   regdst      out  1  destination register is rd (1) or rt (0)
//   regwrite    out  1  register file write enable
//   ULAcontrol  out  3  ALU operation select
//   illegal     out  1  unsupported op/funct (combinational)
//   err_sticky  out  1  registered sticky copy of illegal
// -----------------------------------------------------------------------------
module controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       memread,
  output logic       pcsrc,
  output logic       ULAsrc,
  output logic       regdst,
  output logic       regwrite,
  output logic [2:0] ULAcontrol,
  output logic       illegal,
  output logic       err_sticky
);

  // Supported opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Supported R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Maps an R-type function field to {valid, alu_op}. An unknown funct returns
  // valid=0 with the ADD encoding, so the ALU select stays well defined.
  function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
    logic [3:0] res;
    case (fn)
      FN_ADD:  res = {1'b1, ALU_ADD};
      FN_SUB:  res = {1'b1, ALU_SUB};
      FN_AND:  res = {1'b1, ALU_AND};
      FN_OR:   res = {1'b1, ALU_OR};
      FN_SLT:  res = {1'b1, ALU_SLT};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

  logic [3:0] rtype_dec_s;
  logic       err_sticky_d;
  logic       err_sticky_q;

  assign rtype_dec_s = rtype_alu(funct);

  // Main decode: the defaults describe a safe no-op, and each opcode raises only its own enables
  always_comb begin
    memtoreg   = 1'b0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    pcsrc      = 1'b0;
    ULAsrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    ULAcontrol = ALU_ADD;
    illegal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (rtype_dec_s[3]) begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          ULAcontrol = rtype_dec_s[2:0];
        end else begin
          // Unknown funct: no architectural side effects
          illegal    = 1'b1;
          ULAcontrol = ALU_ADD;
        end
      end
      OP_LW: begin
        memtoreg = 1'b1;
        memread  = 1'b1;
        ULAsrc   = 1'b1;
        regwrite = 1'b1;
      end
      OP_SW: begin
        memwrite = 1'b1;
        ULAsrc   = 1'b1;
      end
      OP_BEQ: begin
        ULAcontrol = ALU_SUB;
        pcsrc      = zero;
      end
      OP_ADDI: begin
        ULAsrc   = 1'b1;
        regwrite = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Next state of the sticky flag: once set, it stays set until reset
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (illegal) begin
      err_sticky_d = 1'b1;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // Sticky error register; the asynchronous reset wins over a simultaneous illegal decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
//
// Self-checking bench for controller. A behavioural model derives each output
// from instruction-class predicates. A separately tracked expected value models
// err_sticky. Directed cases come first, followed by randomized op/funct/zero/
// rst_n stimulus.
// -----------------------------------------------------------------------------
module tb_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memtoreg, memwrite, memread, pcsrc, ULAsrc, regdst, regwrite;
  logic [2:0] ULAcontrol;
  logic       illegal;
  logic       err_sticky;

  int checks_r = 0;
  int errors_r = 0;
  logic sticky_exp_r;

  controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memtoreg   (memtoreg),
    .memwrite   (memwrite),
    .memread    (memread),
    .pcsrc      (pcsrc),
    .ULAsrc     (ULAsrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .ULAcontrol (ULAcontrol),
    .illegal    (illegal),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares an observed value with its expected value and counts the result
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h (op=%b funct=%b zero=%b rst_n=%b)",
               tag, obs, exp, op, funct, zero, rst_n);
    end
  endtask

  // Reference model. The result is packed as
  // {illegal, memtoreg, memwrite, memread, pcsrc, ULAsrc, regdst, regwrite, alu[2:0]}.
  function automatic logic [10:0] model(input logic [5:0] o, input logic [5:0] f, input logic z);
    logic [5:0] fn_tab [5];
    logic [2:0] alu_tab [5];
    logic is_r, is_lw, is_sw, is_beq, is_addi, r_ok, ill;
    logic [2:0] r_alu, alu;
    fn_tab  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    alu_tab = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7};
    is_r    = (o == 6'd0);
    is_lw   = (o == 6'd35);
    is_sw   = (o == 6'd43);
    is_beq  = (o == 6'd4);
    is_addi = (o == 6'd8);
    r_ok    = 1'b0;
    r_alu   = 3'd2;
    for (int i = 0; i < 5; i++) begin
      if (f == fn_tab[i]) begin
        r_ok  = is_r;
        r_alu = alu_tab[i];
      end
    end
    ill = !(r_ok || is_lw || is_sw || is_beq || is_addi);
    alu = r_ok ? r_alu : (is_beq ? 3'd6 : 3'd2);
    return {ill, is_lw, is_sw, is_lw, is_beq & z, is_lw | is_sw | is_addi,
            r_ok, r_ok | is_lw | is_addi, alu};
  endfunction

  function automatic logic [10:0] observed();
    return {illegal, memtoreg, memwrite, memread, pcsrc, ULAsrc, regdst, regwrite, ULAcontrol};
  endfunction

  // Drives one decode vector, waits 1 time unit, then checks all combinational outputs
  task automatic apply(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z);
    op    = o;
    funct = f;
    zero  = z;
    #1;
    check_eq(tag, {21'd0, observed()}, {21'd0, model(o, f, z)});
  endtask

  // Advances to the next rising edge, updates the sticky expectation and checks err_sticky
  task automatic edge_check(input string tag);
    logic ill_now;
    ill_now = model(op, funct, zero)[10];
    @(posedge clk);
    if (!rst_n) sticky_exp_r = 1'b0;
    else if (ill_now) sticky_exp_r = 1'b1;
    else sticky_exp_r = sticky_exp_r;
    #1;
    check_eq(tag, {31'd0, err_sticky}, {31'd0, sticky_exp_r});
  endtask

  initial begin
    logic [5:0] fn_legal [5];
    logic [5:0] op_legal [4];
    logic [5:0] o, f;
    fn_legal = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    op_legal = '{6'd35, 6'd43, 6'd4, 6'd8};

    // Reset state; the decode must stay live while reset is asserted
    rst_n = 1'b0;
    sticky_exp_r = 1'b0;
    apply("rst_decode_add", 6'd0, 6'b100000, 1'b0);
    check_eq("rst_sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decodes
    apply("add", 6'b000000, 6'b100000, 1'b0);
    check_eq("add_direct", {21'd0, observed()}, {21'd0, 11'b0_0000011_010});
    apply("sub_zero1", 6'b000000, 6'b100010, 1'b1);
    check_eq("sub_direct", {21'd0, observed()}, {21'd0, 11'b0_0000011_110});
    apply("and", 6'b000000, 6'b100100, 1'b0);
    apply("or", 6'b000000, 6'b100101, 1'b1);
    apply("slt", 6'b000000, 6'b101010, 1'b0);
    apply("lw", 6'b100011, 6'b010101, 1'b1);
    check_eq("lw_direct", {21'd0, observed()}, {21'd0, 11'b0_1010101_010});
    apply("sw", 6'b101011, 6'b111111, 1'b0);
    check_eq("sw_direct", {21'd0, observed()}, {21'd0, 11'b0_0100100_010});
    apply("beq_z0", 6'b000100, 6'b000000, 1'b0);
    check_eq("beq_pcsrc0", {31'd0, pcsrc}, 32'd0);
    apply("beq_z1", 6'b000100, 6'b000000, 1'b1);
    check_eq("beq_pcsrc1", {31'd0, pcsrc}, 32'd1);
    apply("addi", 6'b001000, 6'b100010, 1'b1);
    edge_check("sticky_legal_hold0");

    // An illegal R-type funct sets the sticky flag
    @(negedge clk);
    apply("r_bad_funct", 6'b000000, 6'b000001, 1'b1);
    check_eq("r_bad_direct", {21'd0, observed()}, {21'd0, 11'b1_0000000_010});
    edge_check("sticky_set_rbad");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sticky_exp_r = 1'b0;
    check_eq("sticky_async_clr0", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // An illegal opcode sets the sticky flag, which then holds
    apply("op_3f", 6'b111111, 6'b100000, 1'b1);
    check_eq("op_3f_direct", {21'd0, observed()}, {21'd0, 11'b1_0000000_010});
    edge_check("sticky_set");
    @(negedge clk);
    apply("lw_after_ill", 6'b100011, 6'b000000, 1'b0);
    edge_check("sticky_hold");
    // Reset clears the flag immediately, without a clock edge
    @(negedge clk);
    apply("op_3f_again", 6'b111111, 6'b000000, 1'b0);
    rst_n = 1'b0;
    #1;
    sticky_exp_r = 1'b0;
    check_eq("sticky_async_clr", {31'd0, err_sticky}, 32'd0);
    check_eq("rst_no_decode_effect", {31'd0, illegal}, 32'd1);
    // Reset wins over an illegal decode at a clock edge
    edge_check("reset_wins");
    @(negedge clk);
    rst_n = 1'b1;
    apply("addi_post_rst", 6'b001000, 6'b000000, 1'b0);
    edge_check("post_rst_legal");
    @(negedge clk);
    apply("op_3f_post_rst", 6'b111111, 6'b000000, 1'b0);
    edge_check("post_rst_set");

    // Randomized stimulus
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0, 1, 2: o = 6'd0;
        3, 4, 5: o = op_legal[$urandom_range(0, 3)];
        default: o = 6'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) f = fn_legal[$urandom_range(0, 4)];
      else f = 6'($urandom);
      rst_n = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      apply("rand_decode", o, f, 1'($urandom));
      if (!rst_n) begin
        sticky_exp_r = 1'b0;
        check_eq("rand_async_clr", {31'd0, err_sticky}, 32'd0);
      end
      edge_check("rand_sticky");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule
